rf_wb_arbiter: RTL

- Shares the single write port of the 16x16 register file between two writeback requesters: the ALU and the load unit.
- Uses round-robin arbitration with valid/ready handshakes.
- Keeps a per-register pending-write scoreboard so the issue stage can detect read-after-write hazards.
- Drives the register file's WriteRgAddr/WriteData from registered outputs. When idle it presents address 0, and the register file discards that write.

---
 rtl/rf_wb_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter for the shared register-file write port, with
// a pending-write scoreboard used by issue for read-after-write hazard checks.
module rf_wb_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16,
   parameter int NREGS  = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_fire,
   output logic [CNT_W-1:0]  drop_cnt
);

   typedef enum logic {PTR_ALU = 1'b0, PTR_LD = 1'b1} ptr_t;

   localparam logic [ADDR_W:0]  NREGS_EXT = (ADDR_W+1)'(NREGS);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   ptr_t              ptrReg, ptrNext;
   logic              grantAlu, grantLd, anyGrant;
   logic [ADDR_W-1:0] selAddr;
   logic [DATA_W-1:0] selData;
   logic              selMapped, selUnmapped, issSet;
   logic [ADDR_W-1:0] wrAddrReg, wrAddrNext;
   logic [DATA_W-1:0] wrDataReg, wrDataNext;
   logic              wrFireReg, wrFireNext;
   logic [CNT_W-1:0]  dropCntReg, dropCntNext;
   logic [NREGS-1:0]  busyReg, busyNext;
   logic              rdBusy1, rdBusy2;

   // Grants are masked while reset is held so nothing is handshaken during reset.
   always_comb begin
      grantAlu = rst & alu_valid & (~ld_valid | (ptrReg == PTR_ALU));
      grantLd  = rst & ld_valid & (~alu_valid | (ptrReg == PTR_LD));
      anyGrant = grantAlu | grantLd;
      selAddr  = grantLd ? ld_addr : alu_addr;
      selData  = grantLd ? ld_data : alu_data;
      selMapped   = (selAddr != '0) && ({1'b0, selAddr} < NREGS_EXT);
      selUnmapped = ({1'b0, selAddr} >= NREGS_EXT);
      issSet      = iss_valid && (iss_addr != '0) && ({1'b0, iss_addr} < NREGS_EXT);
   end

   always_comb begin
      ptrNext     = ptrReg;
      wrAddrNext  = '0;
      wrDataNext  = '0;
      wrFireNext  = 1'b0;
      dropCntNext = dropCntReg;
      if (grantAlu) begin
         ptrNext = PTR_LD;
      end else if (grantLd) begin
         ptrNext = PTR_ALU;
      end
      if (anyGrant) begin
         if (selMapped) begin
            wrAddrNext = selAddr;
            wrDataNext = selData;
            wrFireNext = 1'b1;
         end else if (selUnmapped && (dropCntReg != CNT_MAX)) begin
            dropCntNext = dropCntReg + 1'b1;
         end
      end
   end

   // A new issue to a register overrides the retiring write to the same register.
   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : gBusy
         assign busyNext[gi] = (issSet && (iss_addr == ADDR_W'(gi))) ||
                               (busyReg[gi] && !(wrFireReg && (wrAddrReg == ADDR_W'(gi))));
      end
   endgenerate

   always_comb begin
      rdBusy1 = 1'b0;
      rdBusy2 = 1'b0;
      for (int i = 1; i < NREGS; i++) begin
         if (rd_addr1 == ADDR_W'(i)) rdBusy1 = busyReg[i];
         if (rd_addr2 == ADDR_W'(i)) rdBusy2 = busyReg[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptrReg     <= PTR_LD;
         wrAddrReg  <= '0;
         wrDataReg  <= '0;
         wrFireReg  <= 1'b0;
         dropCntReg <= '0;
         busyReg    <= '0;
      end else begin
         ptrReg     <= ptrNext;
         wrAddrReg  <= wrAddrNext;
         wrDataReg  <= wrDataNext;
         wrFireReg  <= wrFireNext;
         dropCntReg <= dropCntNext;
         busyReg    <= busyNext;
      end
   end

   assign alu_ready = grantAlu;
   assign ld_ready  = grantLd;
   assign rd_busy1  = rdBusy1;
   assign rd_busy2  = rdBusy2;
   assign wr_addr   = wrAddrReg;
   assign wr_data   = wrDataReg;
   assign wr_fire   = wrFireReg;
   assign drop_cnt  = dropCntReg;

endmodule
